// File: rtl/stage_id_if.sv
// ----------------------------------------------------------------------------
//  Module      : stage_id_if
//  Description : Bus bundle between the IF/ID latch, hazard sources, write-back
//                and the ID/EX latch of the decode stage.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface stage_id_if;
    logic        enable;
    logic [31:0] inInstruction;
    logic [31:0] inPostPc;
    logic        inRegWriteWB;
    logic [4:0]  inWriteRegWB;
    logic [31:0] inWriteDataWB;
    logic        inMemReadEX;
    logic        inRegWriteEX;
    logic [4:0]  inWriteRegEX;
    logic        inRegWriteMEM;
    logic [4:0]  inWriteRegMEM;
    logic        outPCWrite;
    logic        outIF_IDWrite;
    logic        outIF_Flush;
    logic        outPCSrc;
    logic        outJump;
    logic [31:0] outAddId;
    logic [31:0] outJumpAddr;
    logic [31:0] outReadData1;
    logic [31:0] outReadData2;
    logic [31:0] outSignExt;
    logic [4:0]  outRs;
    logic [4:0]  outRt;
    logic [4:0]  outRd;
    logic [31:0] outPostPc;
    logic        outRegWrite;
    logic        outMemRead;
    logic        outMemWrite;
    logic        outMemToReg;
    logic        outRegDst;
    logic        outALUSrc;
    logic [1:0]  outALUOp;

    modport slave (
        input  enable, inInstruction, inPostPc,
               inRegWriteWB, inWriteRegWB, inWriteDataWB,
               inMemReadEX, inRegWriteEX, inWriteRegEX,
               inRegWriteMEM, inWriteRegMEM,
        output outPCWrite, outIF_IDWrite, outIF_Flush, outPCSrc, outJump,
               outAddId, outJumpAddr, outReadData1, outReadData2, outSignExt,
               outRs, outRt, outRd, outPostPc,
               outRegWrite, outMemRead, outMemWrite, outMemToReg,
               outRegDst, outALUSrc, outALUOp
    );

    modport master (
        output enable, inInstruction, inPostPc,
               inRegWriteWB, inWriteRegWB, inWriteDataWB,
               inMemReadEX, inRegWriteEX, inWriteRegEX,
               inRegWriteMEM, inWriteRegMEM,
        input  outPCWrite, outIF_IDWrite, outIF_Flush, outPCSrc, outJump,
               outAddId, outJumpAddr, outReadData1, outReadData2, outSignExt,
               outRs, outRt, outRd, outPostPc,
               outRegWrite, outMemRead, outMemWrite, outMemToReg,
               outRegDst, outALUSrc, outALUOp
    );
endinterface

`default_nettype wire

// File: rtl/stage_id.sv
// ----------------------------------------------------------------------------
//  Module      : stage_id
//  Description : MIPS decode stage: regfile, decoder, hazard unit, branch/jump
//                resolution and ID/EX latch. Optional REGFILE_BYPASS_EN macro
//                enables same-cycle write-back forwarding into the reads.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module stage_id #(
    parameter int          REG_CNT  = 32,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    stage_id_if.slave     bus
);
    localparam logic [5:0] c_OP_R    = 6'h00;
    localparam logic [5:0] c_OP_J    = 6'h02;
    localparam logic [5:0] c_OP_BEQ  = 6'h04;
    localparam logic [5:0] c_OP_BNE  = 6'h05;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_LW   = 6'h23;
    localparam logic [5:0] c_OP_SW   = 6'h2B;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] post_pc;
    } idex_t;

    logic [31:0] rf_q [REG_CNT];
    idex_t       idex_q, idex_d;

    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_sext;
    ctrl_t       w_ctrl;
    logic        w_is_branch, w_is_bne, w_is_jump, w_uses_rt;

    assign w_op   = bus.inInstruction[31:26];
    assign w_rs   = bus.inInstruction[25:21];
    assign w_rt   = bus.inInstruction[20:16];
    assign w_rd   = bus.inInstruction[15:11];
    assign w_sext = {{16{bus.inInstruction[15]}}, bus.inInstruction[15:0]};

    always_comb begin
        w_ctrl      = '0;
        w_is_branch = 1'b0;
        w_is_bne    = 1'b0;
        w_is_jump   = 1'b0;
        w_uses_rt   = 1'b0;
        if (bus.inInstruction != NOP_WORD) begin
            case (w_op)
                c_OP_R: begin
                    w_ctrl.reg_dst   = 1'b1;
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.alu_op    = 2'b10;
                    w_uses_rt        = 1'b1;
                end
                c_OP_LW: begin
                    w_ctrl.alu_src    = 1'b1;
                    w_ctrl.mem_read   = 1'b1;
                    w_ctrl.mem_to_reg = 1'b1;
                    w_ctrl.reg_write  = 1'b1;
                end
                c_OP_SW: begin
                    w_ctrl.alu_src   = 1'b1;
                    w_ctrl.mem_write = 1'b1;
                    w_uses_rt        = 1'b1;
                end
                c_OP_BEQ, c_OP_BNE: begin
                    w_ctrl.alu_op = 2'b01;
                    w_is_branch   = 1'b1;
                    w_is_bne      = (w_op == c_OP_BNE);
                    w_uses_rt     = 1'b1;
                end
                c_OP_ADDI: begin
                    w_ctrl.alu_src   = 1'b1;
                    w_ctrl.reg_write = 1'b1;
                end
                c_OP_J:  w_is_jump = 1'b1;
                default: ;
            endcase
        end
    end

    // Specifier matches against downstream writers; $0 never counts as a hazard.
    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;
    assign w_ex_rs  = (w_rs != 5'd0) && (bus.inWriteRegEX  == w_rs);
    assign w_ex_rt  = (w_rt != 5'd0) && w_uses_rt && (bus.inWriteRegEX  == w_rt);
    assign w_mem_rs = (w_rs != 5'd0) && (bus.inWriteRegMEM == w_rs);
    assign w_mem_rt = (w_rt != 5'd0) && w_uses_rt && (bus.inWriteRegMEM == w_rt);
    assign w_wb_rs  = (w_rs != 5'd0) && bus.inRegWriteWB && (bus.inWriteRegWB == w_rs);
    assign w_wb_rt  = (w_rt != 5'd0) && w_uses_rt && bus.inRegWriteWB && (bus.inWriteRegWB == w_rt);

    logic w_load_use, w_br_stall, w_wb_stall, w_stall;
    assign w_load_use = bus.inMemReadEX && (w_ex_rs || w_ex_rt);
    assign w_br_stall = w_is_branch &&
                        ((bus.inRegWriteEX  && (w_ex_rs  || w_ex_rt)) ||
                         (bus.inRegWriteMEM && (w_mem_rs || w_mem_rt)));
    logic [31:0] w_rd1, w_rd2;
`ifdef REGFILE_BYPASS_EN
    assign w_wb_stall = 1'b0;
    assign w_rd1 = (w_rs == 5'd0) ? 32'd0 : (w_wb_rs ? bus.inWriteDataWB : rf_q[w_rs]);
    assign w_rd2 = (w_rt == 5'd0) ? 32'd0 :
                   ((bus.inRegWriteWB && bus.inWriteRegWB == w_rt) ? bus.inWriteDataWB : rf_q[w_rt]);
`else
    // Without forwarding, a read racing a write-back waits one cycle for the array.
    assign w_wb_stall = w_wb_rs || w_wb_rt;
    assign w_rd1 = (w_rs == 5'd0) ? 32'd0 : rf_q[w_rs];
    assign w_rd2 = (w_rt == 5'd0) ? 32'd0 : rf_q[w_rt];
`endif
    assign w_stall = w_load_use || w_br_stall || w_wb_stall;

    logic w_taken, w_jump;
    assign w_taken = w_is_branch && !w_stall && (w_is_bne ? (w_rd1 != w_rd2) : (w_rd1 == w_rd2));
    assign w_jump  = w_is_jump && !w_stall;

    assign bus.outPCWrite    = bus.enable && !w_stall;
    assign bus.outIF_IDWrite = bus.enable && !w_stall;
    assign bus.outPCSrc      = w_taken;
    assign bus.outJump       = w_jump;
    assign bus.outIF_Flush   = w_taken || w_jump;
    assign bus.outAddId      = bus.inPostPc + {w_sext[29:0], 2'b00};
    assign bus.outJumpAddr   = {bus.inPostPc[31:28], bus.inInstruction[25:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
        end else if (bus.enable && bus.inRegWriteWB && bus.inWriteRegWB != 5'd0) begin
            rf_q[bus.inWriteRegWB] <= bus.inWriteDataWB;
        end
    end

    always_comb begin
        idex_d         = '0;
        idex_d.ctrl    = w_stall ? ctrl_t'('0) : w_ctrl;
        idex_d.rd1     = w_rd1;
        idex_d.rd2     = w_rd2;
        idex_d.sext    = w_sext;
        idex_d.rs      = w_rs;
        idex_d.rt      = w_rt;
        idex_d.rd      = w_rd;
        idex_d.post_pc = bus.inPostPc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)          idex_q <= '0;
        else if (bus.enable) idex_q <= idex_d;
    end

    assign bus.outReadData1 = idex_q.rd1;
    assign bus.outReadData2 = idex_q.rd2;
    assign bus.outSignExt   = idex_q.sext;
    assign bus.outRs        = idex_q.rs;
    assign bus.outRt        = idex_q.rt;
    assign bus.outRd        = idex_q.rd;
    assign bus.outPostPc    = idex_q.post_pc;
    assign bus.outRegWrite  = idex_q.ctrl.reg_write;
    assign bus.outMemRead   = idex_q.ctrl.mem_read;
    assign bus.outMemWrite  = idex_q.ctrl.mem_write;
    assign bus.outMemToReg  = idex_q.ctrl.mem_to_reg;
    assign bus.outRegDst    = idex_q.ctrl.reg_dst;
    assign bus.outALUSrc    = idex_q.ctrl.alu_src;
    assign bus.outALUOp     = idex_q.ctrl.alu_op;
endmodule

`default_nettype wire
